// File: rtl/count_arb_pkg.sv
// Shared types and defaults for the counting arbiter controller.
package count_arb_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/count_arb_ctrl.sv
// Arbitrates two requesters and runs a shared counter up to the winner's latched target.
module count_arb_ctrl
  import count_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             done_id
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [1:0]       arb_gnt;

  rr_arb2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    tgt_d     = tgt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        q_d    = '0;
        gnt_d  = 2'b00;
        busy_d = 1'b0;
        if (|req) begin
          state_d = StCount;
          gnt_d   = arb_gnt;
          last_d  = arb_gnt[1];
          tgt_d   = arb_gnt[1] ? tgt1 : tgt0;
          busy_d  = 1'b1;
        end
      end
      StCount: begin
        // Abort or loss of the granted request wins over reaching the target.
        if (abort || ((req & gnt_q) == 2'b00)) begin
          state_d = StIdle;
          q_d     = '0;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
        end else if (q_q == tgt_q) begin
          state_d   = StDone;
          done_d    = 1'b1;
          done_id_d = gnt_q[1];
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        q_d     = '0;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        q_d     = '0;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      q_q       <= '0;
      tgt_q     <= '0;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      tgt_q     <= tgt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign q       = q_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: doc/count_arb_ctrl.md
COUNT_ARB_CTRL -- requirements
Module: count_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: counter and target width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  2  level request per requester; bit i = requester i.
REQ-005 tgt0  input  WIDTH  terminal count for requester 0; sampled only at grant.
REQ-006 tgt1  input  WIDTH  terminal count for requester 1; sampled only at grant.
REQ-007 abort  input  1  cancel the active job.
REQ-008 gnt  output  2  one-hot grant; all-zero when no job is active.
REQ-009 busy  output  1  high in COUNT and DONE states.
REQ-010 q  output  WIDTH  shared counter value.
REQ-011 done  output  1  one-cycle pulse on job completion.
REQ-012 done_id  output  1  index of the requester whose job completed; valid while done=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-014 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-015 IDLE: gnt=0, busy=0, q=0 and done=0.
REQ-016 IDLE with any req bit high SHALL, at the next edge, enter COUNT, set gnt to the winner, clear q to 0 and latch the winner's tgt into an internal target register.
REQ-017 Arbitration SHALL be round-robin.
- A single request wins outright.
- With both requests high, the requester that was not the last winner wins.
- After reset the last winner is 1, so requester 0 wins the first tie.
REQ-018 The last-winner pointer SHALL update at grant, not at completion.
REQ-019 COUNT: q SHALL increment by 1 per cycle while q != target.
REQ-020 COUNT: when q == target, the next edge SHALL enter DONE and hold q.
REQ-021 q SHALL never exceed the latched target and SHALL never wrap, including for target = 2^WIDTH-1.
REQ-022 Latency: with req rising before edge 0, the sequence SHALL be:
- q=0 after edge 1;
- q=T after edge 1+T;
- done=1 after edge 2+T;
- IDLE after edge 3+T.
REQ-023 Target 0 SHALL give one COUNT cycle with q=0, then DONE.
REQ-024 DONE: done=1, done_id=winner, gnt held and q held for exactly one cycle; the next edge SHALL enter IDLE.
REQ-025 In COUNT, abort=1 or the granted req bit low SHALL return the FSM to IDLE at the next edge, with q=0, gnt=0 and no done pulse.
REQ-026 Abort in COUNT SHALL take priority over the q == target transition.
REQ-027 abort and req changes during DONE SHALL be ignored; the job still completes.
REQ-028 Changes to tgt0 or tgt1 after grant SHALL NOT affect the active job.
REQ-029 Requests held high SHALL re-arbitrate in IDLE, giving at least one IDLE cycle between jobs.

Reset
REQ-030 rst high SHALL asynchronously force:
- state to IDLE;
- q, gnt, busy, done and done_id to 0;
- the target register to 0;
- the last-winner pointer to 1.
REQ-031 Reset asserted mid-COUNT SHALL discard the job without a done pulse.
REQ-032 After reset deasserts, the first active clock edge SHALL behave as an IDLE cycle.

Structure
REQ-033 Package count_arb_pkg SHALL hold the state enum (IDLE, COUNT, DONE) and the default WIDTH constant.
REQ-034 Round-robin selection SHALL be a sub-module rr_arb2 with inputs req[1:0] and last, and output a one-hot grant.
REQ-035 The counter, target register and FSM SHALL be in count_arb_ctrl.

Verification
REQ-036 Single request: req=01, tgt0=3 -> q=0,1,2,3 on edges 1-4; done=1 with done_id=0 after edge 5; gnt=00 after edge 6.
REQ-037 Tie fairness: req=11 held, tgt0=1, tgt1=2 -> the first job goes to requester 0 and the second to requester 1, with an IDLE cycle between them.
REQ-038 Boundary targets: tgt1=0 -> done after edge 2. tgt0=15 -> q reaches 15 with no wrap to 0.
REQ-039 Abort: abort=1 pulsed when q=2 with target 5 -> IDLE with q=0 after the next edge and no done pulse. A second case drops the granted req at q=2 and requires the same response.
REQ-040 Reset mid-job: rst asserted asynchronously at q=4 -> all outputs are 0 immediately. After release, req=11 is granted to requester 0.
REQ-041 Target stability: tgt0 changes from 2 to 9 during COUNT -> the job still ends at q=2.
